// File: rtl/rollover_tally.sv
// Two-digit BCD tally of rising edges on a modulo counter's wrap output, with a freezable display and a captured fraction.
// Latency: one Store edge from Q_in rising to the display update. Backpressure: none; Hold freezes only the display.
module rollover_tally #(
  parameter int TENS_MAX = 9,
  parameter bit SAT      = 1'b0
) (
  input  logic       Store,
  input  logic       Reset,
  input  logic       Q_in,
  input  logic [2:0] B_in,
  input  logic       Enable,
  input  logic       Hold,
  input  logic       Clear,
  output logic [3:0] Ones,
  output logic [3:0] Tens,
  output logic [2:0] Frac,
  output logic       Overflow,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic       q_prev;
  logic       evt, inc, at_max;
  logic [3:0] tally_ones, tally_tens;
  logic [3:0] ones_nxt, tens_nxt;

  assign evt    = Q_in & ~q_prev;
  assign inc    = evt & ((state == RUN) | (state == HOLD));
  assign at_max = (tally_tens == 4'(TENS_MAX)) && (tally_ones == 4'd9);
  assign State  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Enable) state_nxt = RUN;
      RUN:     if (!Enable) state_nxt = IDLE;
               else if (Hold) state_nxt = HOLD;
      HOLD:    if (!Enable) state_nxt = IDLE;
               else if (!Hold) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear wins over a coincident event, so no wrap or saturation is seen.
  always_comb begin
    ones_nxt = tally_ones;
    tens_nxt = tally_tens;
    if (Clear) begin
      ones_nxt = 4'd0;
      tens_nxt = 4'd0;
    end else if (inc) begin
      if (at_max) begin
        if (!SAT) begin
          ones_nxt = 4'd0;
          tens_nxt = 4'd0;
        end
      end else if (tally_ones == 4'd9) begin
        ones_nxt = 4'd0;
        tens_nxt = tally_tens + 4'd1;
      end else begin
        ones_nxt = tally_ones + 4'd1;
      end
    end
  end

  always_ff @(posedge Store) begin
    if (Reset) begin
      state      <= IDLE;
      q_prev     <= 1'b0;
      tally_ones <= 4'd0;
      tally_tens <= 4'd0;
      Ones       <= 4'd0;
      Tens       <= 4'd0;
      Frac       <= 3'd0;
      Overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      q_prev     <= Q_in;
      tally_ones <= ones_nxt;
      tally_tens <= tens_nxt;
      Overflow   <= inc & at_max & ~Clear;
      if (Clear) begin
        Ones <= 4'd0;
        Tens <= 4'd0;
        Frac <= 3'd0;
      end else begin
        // Display tracks the tally except while frozen in HOLD.
        if (state_nxt != HOLD) begin
          Ones <= ones_nxt;
          Tens <= tens_nxt;
        end
        if (state == RUN && state_nxt == HOLD) Frac <= B_in;
      end
    end
  end

endmodule
